// File: rtl/lap_stopwatch_core_if.sv
// Command/status bundle between the key debouncers (master) and the
// stopwatch core (slave).
//   start_pause, lap, reset_cmd, clear : single-cycle command pulses
//   lap_rd_idx                         : lap read index, 0 = newest lap
//   running, split_active, overflow    : status flags
//   timestamp, disp_timestamp          : live / displayed time {h,m,s,cs}
//   lap_count, lap_full, lap_rd_data   : lap buffer status and read data
interface lap_stopwatch_core_if #(
  parameter int unsigned LAP_DEPTH = 8
);
  localparam int unsigned IDX_W = $clog2(LAP_DEPTH);
  localparam int unsigned TS_W  = 28;

  logic             start_pause;
  logic             lap;
  logic             reset_cmd;
  logic             clear;
  logic [IDX_W-1:0] lap_rd_idx;

  logic             running;
  logic             split_active;
  logic             overflow;
  logic [TS_W-1:0]  timestamp;
  logic [TS_W-1:0]  disp_timestamp;
  logic [IDX_W:0]   lap_count;
  logic             lap_full;
  logic [TS_W-1:0]  lap_rd_data;

  modport master (
    output start_pause, lap, reset_cmd, clear, lap_rd_idx,
    input  running, split_active, overflow, timestamp, disp_timestamp,
           lap_count, lap_full, lap_rd_data
  );

  modport slave (
    input  start_pause, lap, reset_cmd, clear, lap_rd_idx,
    output running, split_active, overflow, timestamp, disp_timestamp,
           lap_count, lap_full, lap_rd_data
  );
endinterface

// File: rtl/lap_stopwatch_core.sv
// Stopwatch timing core with a circular lap (split) memory.
// Runs an hour/minute/second/centisecond counter from a clock prescaler,
// captures lap times and drives a display time that can be frozen on a lap.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : lap_stopwatch_core_if slave (commands in, status/time out)
module lap_stopwatch_core #(
  parameter int unsigned TICK_DIV  = 500000,
  parameter int unsigned LAP_DEPTH = 8,
  parameter int unsigned HOUR_MAX  = 24
) (
  input  logic                 clock,
  input  logic                 reset_n,
  lap_stopwatch_core_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(LAP_DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam int unsigned TS_W  = 28;
  localparam int unsigned F_W   = 7;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2,
    S_SPLIT   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              store_lap, zero_time;

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [TS_W-1:0]   ts_q, ts_d, ts_inc;
  logic [TS_W-1:0]   frz_q, frz_d;
  logic [TS_W-1:0]   disp_q, disp_d;
  logic              ovf_q, ovf_d;
  logic              run_q, split_q;
  logic              counting, tick, wrap;

  logic [F_W-1:0]    cs, sec, mins, hr;
  logic [F_W-1:0]    cs_n, sec_n, mins_n, hr_n;

  logic [TS_W-1:0]   mem_q [LAP_DEPTH];
  logic [IDX_W-1:0]  wptr_q, wptr_d, rd_addr;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full_q, full_d, wr_en;
  logic [TS_W-1:0]   rd_q, rd_d;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state; priority reset_cmd > start_pause > lap among commands that act.
  always_comb begin
    state_d   = state_q;
    store_lap = 1'b0;
    zero_time = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_pause) state_d = S_RUNNING;
      end
      S_RUNNING: begin
        if (bus.start_pause) begin
          state_d = S_PAUSED;
        end else if (bus.lap) begin
          state_d   = S_SPLIT;
          store_lap = 1'b1;
        end
      end
      S_PAUSED: begin
        if (bus.reset_cmd) begin
          state_d   = S_IDLE;
          zero_time = 1'b1;
        end else if (bus.start_pause) begin
          state_d = S_RUNNING;
        end
      end
      S_SPLIT: begin
        if (bus.reset_cmd) begin
          state_d = S_RUNNING;
        end else if (bus.start_pause) begin
          state_d = S_PAUSED;
        end else if (bus.lap) begin
          state_d   = S_SPLIT;
          store_lap = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign {hr, mins, sec, cs} = ts_q;

  // One-centisecond increment with full carry ripple; wrap flags the hour rollover.
  always_comb begin
    cs_n   = cs;
    sec_n  = sec;
    mins_n = mins;
    hr_n   = hr;
    wrap   = 1'b0;
    if (cs != 7'd99) begin
      cs_n = cs + 7'd1;
    end else begin
      cs_n = '0;
      if (sec != 7'd59) begin
        sec_n = sec + 7'd1;
      end else begin
        sec_n = '0;
        if (mins != 7'd59) begin
          mins_n = mins + 7'd1;
        end else begin
          mins_n = '0;
          if (hr != F_W'(HOUR_MAX - 1)) begin
            hr_n = hr + 7'd1;
          end else begin
            hr_n = '0;
            wrap = 1'b1;
          end
        end
      end
    end
    ts_inc = {hr_n, mins_n, sec_n, cs_n};
  end

  // Prescaler, time, overflow and display next values.
  always_comb begin
    counting = (state_q == S_RUNNING) || (state_q == S_SPLIT);
    tick     = counting && (presc_q == PRE_W'(TICK_DIV - 1));
    presc_d  = presc_q;
    ts_d     = ts_q;
    ovf_d    = ovf_q;
    frz_d    = frz_q;
    if (zero_time) begin
      presc_d = '0;
      ts_d    = '0;
      ovf_d   = 1'b0;
    end else if (counting) begin
      presc_d = tick ? '0 : presc_q + PRE_W'(1);
      if (tick) begin
        ts_d = ts_inc;
        if (wrap) ovf_d = 1'b1;
      end
    end
    // Lap captures the pre-increment time seen at the command edge.
    if (store_lap) frz_d = ts_q;
    disp_d = (state_d == S_SPLIT) ? frz_d : ts_d;
  end

  // Timer datapath and status registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      ts_q    <= '0;
      ovf_q   <= 1'b0;
      frz_q   <= '0;
      disp_q  <= '0;
      run_q   <= 1'b0;
      split_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      ts_q    <= ts_d;
      ovf_q   <= ovf_d;
      frz_q   <= frz_d;
      disp_q  <= disp_d;
      run_q   <= (state_d == S_RUNNING) || (state_d == S_SPLIT);
      split_q <= (state_d == S_SPLIT);
    end
  end

  // Lap buffer pointers; clear beats a simultaneous store.
  always_comb begin
    cnt_d  = cnt_q;
    wptr_d = wptr_q;
    wr_en  = 1'b0;
    if (bus.clear) begin
      cnt_d  = '0;
      wptr_d = '0;
    end else if (store_lap) begin
      wr_en  = 1'b1;
      wptr_d = wptr_q + IDX_W'(1);
      if (cnt_q != CNT_W'(LAP_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end
    full_d = (cnt_d == CNT_W'(LAP_DEPTH));
    // Index 0 is the newest entry, just behind the write pointer.
    rd_addr = wptr_q - IDX_W'(1) - bus.lap_rd_idx;
    rd_d    = ({1'b0, bus.lap_rd_idx} < cnt_q) ? mem_q[rd_addr] : '0;
  end

  // Lap storage and registered read port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < LAP_DEPTH; i++) mem_q[IDX_W'(i)] <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
      rd_q   <= '0;
    end else begin
      if (wr_en) mem_q[wptr_q] <= ts_q;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
      rd_q   <= rd_d;
    end
  end

  assign bus.running        = run_q;
  assign bus.split_active   = split_q;
  assign bus.overflow       = ovf_q;
  assign bus.timestamp      = ts_q;
  assign bus.disp_timestamp = disp_q;
  assign bus.lap_count      = cnt_q;
  assign bus.lap_full       = full_q;
  assign bus.lap_rd_data    = rd_q;
endmodule
